group_or_scan_scheduler: RTL and testbench

- Sequential scheduler for the wide grouped OR-reduction datapath.
- Input vectors are split into NGROUPS groups of GW bits, each gated by an enable bit.
- Each scan visits every group exactly once in round-robin order. Each enabled group with any bit set is presented downstream over a valid/ready handshake.
- Replaces the flat single-cycle OR tree with a time-shared, one-group-per-cycle evaluator. Also reports a per-scan hit summary.

---
 rtl/group_or_scan_scheduler.sv | 144 ++++++++++++++
 tb/tb_group_or_scan_scheduler.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/group_or_scan_scheduler.sv
// group_or_scan_scheduler: time-shared grouped OR evaluator.
// Visits one group per cycle round-robin and presents hit groups downstream.
module group_or_scan_scheduler #(
   parameter int NGROUPS = 8,
   parameter int GW      = 32,
   localparam int IW     = $clog2(NGROUPS)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [NGROUPS-1:0]    grp_en,
   input  logic [NGROUPS*GW-1:0] grp_vec,
   input  logic                  out_ready,
   output logic                  busy,
   output logic                  out_valid,
   output logic [IW-1:0]         out_grp,
   output logic [GW-1:0]         out_vec,
   output logic                  done,
   output logic                  hit_any,
   output logic [NGROUPS-1:0]    hit_mask
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_SCAN = 2'd1,
      S_HOLD = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t             state_q, state_d;
   logic [IW-1:0]      ptr_q, ptr_d;
   logic [IW-1:0]      cnt_q, cnt_d;
   logic [IW-1:0]      rr_base_q, rr_base_d;
   logic [NGROUPS-1:0] en_q, en_d;
   logic               out_valid_q, out_valid_d;
   logic [IW-1:0]      out_grp_q, out_grp_d;
   logic [GW-1:0]      out_vec_q, out_vec_d;
   logic [NGROUPS-1:0] hit_mask_q, hit_mask_d;
   logic               hit_any_q, hit_any_d;

   logic [GW-1:0]      cur_slice;
   logic               cur_hit;
   logic               last_visit;

   // Select the slice of the group under the scan pointer
   always_comb begin
      cur_slice = '0;
      for (int g = 0; g < NGROUPS; g++) begin
         if (ptr_q == IW'(g)) cur_slice = grp_vec[g*GW +: GW];
      end
   end

   assign cur_hit    = en_q[ptr_q] & (|cur_slice);
   assign last_visit = (cnt_q == IW'(NGROUPS-1));

   // Next-state and datapath updates for the scan FSM
   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      cnt_d       = cnt_q;
      rr_base_d   = rr_base_q;
      en_d        = en_q;
      out_valid_d = out_valid_q;
      out_grp_d   = out_grp_q;
      out_vec_d   = out_vec_q;
      hit_mask_d  = hit_mask_q;
      hit_any_d   = hit_any_q;
      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               en_d       = grp_en;
               ptr_d      = rr_base_q;
               cnt_d      = '0;
               hit_mask_d = '0;
               hit_any_d  = 1'b0;
               state_d    = S_SCAN;
            end
         end
         S_SCAN: begin
            if (cur_hit) begin
               out_grp_d   = ptr_q;
               out_vec_d   = cur_slice;
               out_valid_d = 1'b1;
               state_d     = S_HOLD;
            end else begin
               ptr_d = ptr_q + 1'b1;
               cnt_d = cnt_q + 1'b1;
               if (last_visit) state_d = S_DONE;
            end
         end
         S_HOLD: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               hit_mask_d  = hit_mask_q | (NGROUPS'(1) << ptr_q);
               hit_any_d   = 1'b1;
               rr_base_d   = ptr_q + 1'b1;
               ptr_d       = ptr_q + 1'b1;
               cnt_d       = cnt_q + 1'b1;
               state_d     = last_visit ? S_DONE : S_SCAN;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State register with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         ptr_q       <= '0;
         cnt_q       <= '0;
         rr_base_q   <= '0;
         en_q        <= '0;
         out_valid_q <= 1'b0;
         out_grp_q   <= '0;
         out_vec_q   <= '0;
         hit_mask_q  <= '0;
         hit_any_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         cnt_q       <= cnt_d;
         rr_base_q   <= rr_base_d;
         en_q        <= en_d;
         out_valid_q <= out_valid_d;
         out_grp_q   <= out_grp_d;
         out_vec_q   <= out_vec_d;
         hit_mask_q  <= hit_mask_d;
         hit_any_q   <= hit_any_d;
      end
   end

   assign busy      = (state_q != S_IDLE);
   assign done      = (state_q == S_DONE);
   assign out_valid = out_valid_q;
   assign out_grp   = out_grp_q;
   assign out_vec   = out_vec_q;
   assign hit_mask  = hit_mask_q;
   assign hit_any   = hit_any_q;

endmodule

// File: tb/tb_group_or_scan_scheduler.sv
// tb_group_or_scan_scheduler: directed checks of the grouped OR scan scheduler.
// Each task drives one scenario and compares against hand-derived values.
module tb_group_or_scan_scheduler;

   logic         clk;
   logic         rst;
   logic         start;
   logic [7:0]   grp_en;
   logic [255:0] grp_vec;
   logic         out_ready;
   logic         busy;
   logic         out_valid;
   logic [2:0]   out_grp;
   logic [31:0]  out_vec;
   logic         done;
   logic         hit_any;
   logic [7:0]   hit_mask;

   int pass_cnt = 0;
   int total    = 0;

   int          done_cyc;
   int          first_cyc;
   int          busy_cnt;
   int          served_n;
   logic [31:0] served_seq;
   logic [31:0] first_vec;

   group_or_scan_scheduler dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .grp_en    (grp_en),
      .grp_vec   (grp_vec),
      .out_ready (out_ready),
      .busy      (busy),
      .out_valid (out_valid),
      .out_grp   (out_grp),
      .out_vec   (out_vec),
      .done      (done),
      .hit_any   (hit_any),
      .hit_mask  (hit_mask)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Start a scan with out_ready held high and collect served groups
   task automatic run_scan(input logic [7:0] en, input logic [255:0] vec,
                           input bit disturb);
      done_cyc   = -1;
      first_cyc  = -1;
      busy_cnt   = 0;
      served_n   = 0;
      served_seq = '0;
      first_vec  = '0;
      grp_en     = en;
      grp_vec    = vec;
      out_ready  = 1'b1;
      start      = 1'b1;
      step();
      start = 1'b0;
      for (int c = 1; c <= 40; c++) begin
         if (busy) busy_cnt++;
         if (out_valid) begin
            if (first_cyc < 0) begin
               first_cyc = c;
               first_vec = out_vec;
            end
            served_seq = (served_seq << 4) | {29'd0, out_grp};
            served_n++;
         end
         if (done) begin
            done_cyc = c;
            break;
         end
         if (disturb && c >= 2 && c <= 6) begin
            start  = 1'b1;
            grp_en = 8'hFF;
         end else begin
            start = 1'b0;
         end
         step();
      end
      start = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      step();
      step();
      total++;
      if ({busy, out_valid, out_grp, out_vec, done, hit_any, hit_mask} !== '0)
         $display("FAIL reset: got busy=%0b v=%0b grp=%0d vec=%h done=%0b any=%0b mask=%h want all 0",
                  busy, out_valid, out_grp, out_vec, done, hit_any, hit_mask);
      else pass_cnt++;
      rst = 1'b0;
      step();
   endtask

   task automatic test_no_enable();
      run_scan(8'h00, {256{1'b1}}, 1'b0);
      total++;
      if (done_cyc !== 9) $display("FAIL noen_done: got %0d want 9", done_cyc);
      else pass_cnt++;
      total++;
      if (served_n !== 0) $display("FAIL noen_valid: got %0d served want 0", served_n);
      else pass_cnt++;
      total++;
      if (busy_cnt !== 9) $display("FAIL noen_busy: got %0d cycles want 9", busy_cnt);
      else pass_cnt++;
      total++;
      if ({hit_any, hit_mask} !== 9'h000)
         $display("FAIL noen_hits: got any=%0b mask=%h want 0/00", hit_any, hit_mask);
      else pass_cnt++;
      step();
      total++;
      if (busy !== 1'b0) $display("FAIL noen_idle: got busy=%0b want 0", busy);
      else pass_cnt++;
   endtask

   task automatic test_single_hit();
      logic [255:0] v;
      v = '0;
      v[3*32 +: 32] = 32'h0000_0001;
      run_scan(8'hFF, v, 1'b0);
      total++;
      if (first_cyc !== 5) $display("FAIL single_cyc: got %0d want 5", first_cyc);
      else pass_cnt++;
      total++;
      if (served_n !== 1 || served_seq !== 32'h3)
         $display("FAIL single_grp: got n=%0d seq=%h want 1/3", served_n, served_seq);
      else pass_cnt++;
      total++;
      if (first_vec !== 32'h1) $display("FAIL single_vec: got %h want 00000001", first_vec);
      else pass_cnt++;
      total++;
      if (done_cyc !== 10) $display("FAIL single_done: got %0d want 10", done_cyc);
      else pass_cnt++;
      total++;
      if ({hit_any, hit_mask} !== 9'h108)
         $display("FAIL single_hits: got any=%0b mask=%h want 1/08", hit_any, hit_mask);
      else pass_cnt++;
      step();
      run_scan(8'hFF, {256{1'b1}}, 1'b0);
      total++;
      if (served_n !== 8 || served_seq !== 32'h4567_0123)
         $display("FAIL rr_order: got n=%0d seq=%h want 8/45670123", served_n, served_seq);
      else pass_cnt++;
      total++;
      if (done_cyc !== 17) $display("FAIL worst_done: got %0d want 17", done_cyc);
      else pass_cnt++;
      step();
   endtask

   task automatic test_sparse_enable();
      test_reset();
      for (int k = 0; k < 2; k++) begin
         run_scan(8'hA5, {256{1'b1}}, 1'b0);
         total++;
         if (served_n !== 4 || served_seq !== 32'h0257)
            $display("FAIL a5_order%0d: got n=%0d seq=%h want 4/0257", k, served_n, served_seq);
         else pass_cnt++;
         total++;
         if (hit_mask !== 8'hA5) $display("FAIL a5_mask%0d: got %h want a5", k, hit_mask);
         else pass_cnt++;
         total++;
         if (done_cyc !== 13) $display("FAIL a5_done%0d: got %0d want 13", k, done_cyc);
         else pass_cnt++;
         step();
      end
   endtask

   task automatic test_hold();
      int vcyc;
      logic [255:0] v;
      v = {256{1'b1}};
      v[6*32 +: 32] = 32'h1234_5678;
      grp_en    = 8'h40;
      grp_vec   = v;
      out_ready = 1'b0;
      start     = 1'b1;
      step();
      start = 1'b0;
      vcyc  = -1;
      for (int c = 1; c <= 20; c++) begin
         if (out_valid) begin
            vcyc = c;
            break;
         end
         step();
      end
      total++;
      if (vcyc !== 8) $display("FAIL hold_cyc: got %0d want 8", vcyc);
      else pass_cnt++;
      for (int i = 0; i < 10; i++) begin
         grp_vec[6*32 +: 32] = 32'hDEAD_0000 + i;
         out_ready = (i == 9) ? 1'b0 : 1'b0;
         step();
         total++;
         if (out_valid !== 1'b1 || out_grp !== 3'd6 || out_vec !== 32'h1234_5678 || busy !== 1'b1)
            $display("FAIL hold_stable%0d: got v=%0b grp=%0d vec=%h busy=%0b want 1/6/12345678/1",
                     i, out_valid, out_grp, out_vec, busy);
         else pass_cnt++;
      end
      out_ready = 1'b1;
      step();
      total++;
      if (out_valid !== 1'b0 || hit_mask !== 8'h40)
         $display("FAIL hold_hs: got v=%0b mask=%h want 0/40", out_valid, hit_mask);
      else pass_cnt++;
      vcyc = -1;
      for (int c = 0; c < 5; c++) begin
         if (done) begin
            vcyc = c;
            break;
         end
         step();
      end
      total++;
      if (vcyc !== 1 || hit_any !== 1'b1)
         $display("FAIL hold_done: got at %0d any=%0b want 1/1", vcyc, hit_any);
      else pass_cnt++;
      step();
   endtask

   task automatic test_slices();
      logic [255:0] v;
      v = '0;
      v[3*32 +: 32] = '1;
      v[5*32 +: 32] = '1;
      v[4*32 +: 32] = 32'h8000_0001;
      run_scan(8'h10, v, 1'b0);
      total++;
      if (served_n !== 1 || served_seq !== 32'h4 || first_vec !== 32'h8000_0001)
         $display("FAIL slice_vec: got n=%0d seq=%h vec=%h want 1/4/80000001",
                  served_n, served_seq, first_vec);
      else pass_cnt++;
      step();
      v = '0;
      v[2*32 +: 32] = '1;
      v[4*32 +: 32] = '1;
      run_scan(8'h08, v, 1'b0);
      total++;
      if (served_n !== 0 || hit_any !== 1'b0 || done_cyc !== 9)
         $display("FAIL slice_leak: got n=%0d any=%0b done=%0d want 0/0/9",
                  served_n, hit_any, done_cyc);
      else pass_cnt++;
      step();
   endtask

   task automatic test_no_restart();
      run_scan(8'h81, {256{1'b1}}, 1'b1);
      total++;
      if (served_n !== 2 || served_seq !== 32'h70)
         $display("FAIL norestart_order: got n=%0d seq=%h want 2/70", served_n, served_seq);
      else pass_cnt++;
      total++;
      if (hit_mask !== 8'h81 || done_cyc !== 11)
         $display("FAIL norestart_mask: got mask=%h done=%0d want 81/11", hit_mask, done_cyc);
      else pass_cnt++;
      step();
   endtask

   task automatic test_reset_in_hold();
      grp_en    = 8'hFF;
      grp_vec   = {256{1'b1}};
      out_ready = 1'b0;
      start     = 1'b1;
      step();
      start = 1'b0;
      step();
      total++;
      if (out_valid !== 1'b1 || out_grp !== 3'd1)
         $display("FAIL rsthold_pre: got v=%0b grp=%0d want 1/1", out_valid, out_grp);
      else pass_cnt++;
      rst = 1'b1;
      out_ready = 1'b1;
      step();
      rst = 1'b0;
      total++;
      if (busy !== 1'b0 || out_valid !== 1'b0 || hit_mask !== 8'h00 || done !== 1'b0)
         $display("FAIL rsthold_post: got busy=%0b v=%0b mask=%h done=%0b want 0/0/00/0",
                  busy, out_valid, hit_mask, done);
      else pass_cnt++;
      step();
      run_scan(8'hFF, {256{1'b1}}, 1'b0);
      total++;
      if (served_n !== 8 || served_seq !== 32'h0123_4567)
         $display("FAIL rsthold_restart: got n=%0d seq=%h want 8/01234567", served_n, served_seq);
      else pass_cnt++;
   endtask

   initial begin
      rst       = 1'b1;
      start     = 1'b0;
      grp_en    = '0;
      grp_vec   = '0;
      out_ready = 1'b0;
      test_reset();
      test_no_enable();
      test_single_hit();
      test_sparse_enable();
      test_hold();
      test_slices();
      test_no_restart();
      test_reset_in_hold();
      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end

endmodule
